// File: rtl/cmd_frame_filter.sv
// cmd_frame_filter: validates 3-byte command frames (header, opcode, checksum)
// arriving on a valid/ready byte stream. It presents each legal command as a
// registered level on cmd, plus a cmd_valid handshake. Malformed frames and
// stalled frames are reported via err_pulse/err_code/err_count.
module cmd_frame_filter #(
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int         TIMEOUT   = 16,
    parameter int         ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    input  logic                 out_ready,
    output logic                 cmd_valid,
    output logic [2:0]           cmd,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    // The three unused 3-bit encodings fall into the default branch and return to IDLE.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_OPC  = 3'd2,
        S_EMIT = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OPCODE   = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    state_t               state_q;
    logic [TMR_W-1:0]     timer_q;
    logic [2:0]           pending_q;
    logic [2:0]           cmd_q;
    logic                 cmd_valid_q;
    logic                 in_ready_q;
    logic                 err_pulse_q;
    logic [1:0]           err_code_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    logic                 accept;
    logic                 op_legal;
    logic [2:0]           op_cmd;
    logic [7:0]           checksum;
    logic                 timeout_hit;
    logic [ERR_CNT_W-1:0] err_count_d;

    assign accept = in_valid && in_ready_q;

    // Legal opcodes map to the command value held in their low three bits.
    // The pending register therefore stores only those bits, and the checksum
    // rebuilds the full opcode byte by zero-extending them.
    assign checksum = HEADER ^ {5'b0, pending_q};

    // The frame is aborted on the idle cycle that would bring the timer to TIMEOUT.
    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));

    // Saturating increment applied on every entry into ERR.
    assign err_count_d = (err_count_q == {ERR_CNT_W{1'b1}}) ? err_count_q
                                                            : err_count_q + ERR_CNT_W'(1);

    // Decode the opcode byte into legality and the command it selects.
    always_comb begin
        op_legal = 1'b0;
        op_cmd   = 3'h0;
        case (in_data)
            8'h00: begin op_legal = 1'b1; op_cmd = 3'h0; end
            8'h03: begin op_legal = 1'b1; op_cmd = 3'h3; end
            8'h04: begin op_legal = 1'b1; op_cmd = 3'h4; end
            8'h05: begin op_legal = 1'b1; op_cmd = 3'h5; end
            default: begin op_legal = 1'b0; op_cmd = 3'h0; end
        endcase
    end

    // Frame FSM with registered outputs. The timer, pending command and error bookkeeping are updated alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            pending_q   <= 3'h0;
            cmd_q       <= 3'h0;
            cmd_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'd0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    // Non-header bytes are dropped here to resynchronise the stream.
                    if (accept && (in_data == HEADER)) begin
                        state_q <= S_HDR;
                    end
                end

                S_HDR: begin
                    if (accept) begin
                        timer_q <= '0;
                        if (op_legal) begin
                            pending_q <= op_cmd;
                            state_q   <= S_OPC;
                        end else begin
                            state_q     <= S_ERR;
                            in_ready_q  <= 1'b0;
                            err_pulse_q <= 1'b1;
                            err_code_q  <= ERR_OPCODE;
                            err_count_q <= err_count_d;
                        end
                    end else if (timeout_hit) begin
                        timer_q     <= '0;
                        state_q     <= S_ERR;
                        in_ready_q  <= 1'b0;
                        err_pulse_q <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                        err_count_q <= err_count_d;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end

                S_OPC: begin
                    if (accept) begin
                        timer_q <= '0;
                        if (in_data == checksum) begin
                            state_q     <= S_EMIT;
                            in_ready_q  <= 1'b0;
                            cmd_q       <= pending_q;
                            cmd_valid_q <= 1'b1;
                        end else begin
                            state_q     <= S_ERR;
                            in_ready_q  <= 1'b0;
                            err_pulse_q <= 1'b1;
                            err_code_q  <= ERR_CHECKSUM;
                            err_count_q <= err_count_d;
                        end
                    end else if (timeout_hit) begin
                        timer_q     <= '0;
                        state_q     <= S_ERR;
                        in_ready_q  <= 1'b0;
                        err_pulse_q <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                        err_count_q <= err_count_d;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end

                S_EMIT: begin
                    timer_q <= '0;
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        in_ready_q  <= 1'b1;
                        cmd_valid_q <= 1'b0;
                    end
                end

                S_ERR: begin
                    timer_q     <= '0;
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    err_pulse_q <= 1'b0;
                end

                default: begin
                    timer_q    <= '0;
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_cmd_frame_filter.sv
// Directed testbench for cmd_frame_filter. Each scenario task drives its
// stimulus and compares outputs against hand-computed expectations.
module tb_cmd_frame_filter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_ready;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [3:0] err_count;

    int pass_cnt;
    int total_cnt;

    cmd_frame_filter #(
        .HEADER   (8'hA5),
        .TIMEOUT  (16),
        .ERR_CNT_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_ready(out_ready),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .err_pulse(err_pulse),
        .err_code (err_code),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one byte for a single edge. The caller sits 1ns after a rising edge and ends there again.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (cmd !== 3'h0) $display("FAIL reset_cmd: got %h expected %h", cmd, 3'h0); else pass_cnt++;
        total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); else pass_cnt++;
        total_cnt++; if (err_pulse !== 1'b0 || err_code !== 2'd0 || err_count !== 4'd0)
            $display("FAIL reset_err: got pulse=%b code=%0d count=%0d expected 0/0/0", err_pulse, err_code, err_count);
        else pass_cnt++;
        rst = 1'b0;
        idle_cycle();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        $display("txn reset done");
    endtask

    task automatic test_basic_frame();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'hA1);
        total_cnt++; if (cmd_valid !== 1'b1) $display("FAIL basic_cmd_valid: got %b expected 1", cmd_valid); else pass_cnt++;
        total_cnt++; if (cmd !== 3'h4) $display("FAIL basic_cmd: got %h expected %h", cmd, 3'h4); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_emit_in_ready: got %b expected 0", in_ready); else pass_cnt++;
        idle_cycle();
        total_cnt++; if (cmd_valid !== 1'b0 || cmd !== 3'h4)
            $display("FAIL basic_after: got valid=%b cmd=%h expected valid=0 cmd=4", cmd_valid, cmd);
        else pass_cnt++;
        total_cnt++; if (err_count !== 4'd0 || in_ready !== 1'b1)
            $display("FAIL basic_idle: got count=%0d ready=%b expected count=0 ready=1", err_count, in_ready);
        else pass_cnt++;
        $display("txn basic frame A5 04 A1 -> cmd=%h", cmd);
    endtask

    task automatic test_bad_opcode();
        send_byte(8'hA5);
        send_byte(8'h06);
        total_cnt++; if (err_pulse !== 1'b1 || err_code !== 2'd1 || err_count !== 4'd1)
            $display("FAIL badop_err: got pulse=%b code=%0d count=%0d expected 1/1/1", err_pulse, err_code, err_count);
        else pass_cnt++;
        total_cnt++; if (cmd !== 3'h4 || cmd_valid !== 1'b0)
            $display("FAIL badop_cmd: got cmd=%h valid=%b expected cmd=4 valid=0", cmd, cmd_valid);
        else pass_cnt++;
        idle_cycle();
        total_cnt++; if (err_pulse !== 1'b0) $display("FAIL badop_pulse_width: got %b expected 0", err_pulse); else pass_cnt++;
        send_byte(8'h07);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hA6);
        total_cnt++; if (cmd_valid !== 1'b1 || cmd !== 3'h3)
            $display("FAIL badop_resync: got valid=%b cmd=%h expected valid=1 cmd=3", cmd_valid, cmd);
        else pass_cnt++;
        idle_cycle();
        total_cnt++; if (err_count !== 4'd1 || err_code !== 2'd1)
            $display("FAIL badop_no_new_err: got count=%0d code=%0d expected 1/1", err_count, err_code);
        else pass_cnt++;
        $display("txn bad opcode A5 06 then 07 A5 03 A6 -> cmd=%h err_count=%0d", cmd, err_count);
    endtask

    task automatic test_bad_checksum();
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h00);
        total_cnt++; if (err_pulse !== 1'b1 || err_code !== 2'd2 || err_count !== 4'd2)
            $display("FAIL badck_err: got pulse=%b code=%0d count=%0d expected 1/2/2", err_pulse, err_code, err_count);
        else pass_cnt++;
        total_cnt++; if (cmd !== 3'h3 || cmd_valid !== 1'b0)
            $display("FAIL badck_cmd: got cmd=%h valid=%b expected cmd=3 valid=0", cmd, cmd_valid);
        else pass_cnt++;
        idle_cycle();
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'hA0);
        total_cnt++; if (cmd_valid !== 1'b1 || cmd !== 3'h5)
            $display("FAIL badck_good: got valid=%b cmd=%h expected valid=1 cmd=5", cmd_valid, cmd);
        else pass_cnt++;
        idle_cycle();
        total_cnt++; if (err_code !== 2'd2) $display("FAIL badck_code_retained: got %0d expected 2", err_code); else pass_cnt++;
        $display("txn bad checksum A5 05 00 then A5 05 A0 -> cmd=%h", cmd);
    endtask

    task automatic test_timeout();
        logic early_err;
        send_byte(8'hA5);
        early_err = 1'b0;
        for (int i = 0; i < 15; i++) begin
            idle_cycle();
            if (err_pulse !== 1'b0) early_err = 1'b1;
        end
        total_cnt++; if (early_err !== 1'b0) $display("FAIL timeout_early: got %b expected 0", early_err); else pass_cnt++;
        idle_cycle();
        total_cnt++; if (err_pulse !== 1'b1 || err_code !== 2'd3 || err_count !== 4'd3)
            $display("FAIL timeout_err: got pulse=%b code=%0d count=%0d expected 1/3/3", err_pulse, err_code, err_count);
        else pass_cnt++;
        idle_cycle();
        // A byte on the 15th idle cycle restarts the timer, and the OPC state gets its own full window.
        send_byte(8'hA5);
        for (int i = 0; i < 14; i++) idle_cycle();
        send_byte(8'h03);
        early_err = 1'b0;
        for (int i = 0; i < 15; i++) begin
            idle_cycle();
            if (err_pulse !== 1'b0) early_err = 1'b1;
        end
        total_cnt++; if (early_err !== 1'b0) $display("FAIL timeout_prevented: got %b expected 0", early_err); else pass_cnt++;
        send_byte(8'hA6);
        total_cnt++; if (cmd_valid !== 1'b1 || cmd !== 3'h3 || err_count !== 4'd3)
            $display("FAIL timeout_late_frame: got valid=%b cmd=%h count=%0d expected 1/3/3", cmd_valid, cmd, err_count);
        else pass_cnt++;
        idle_cycle();
        $display("txn timeout checks done err_count=%0d", err_count);
    endtask

    task automatic test_back_pressure();
        logic hold_bad;
        out_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'hA5);
        total_cnt++; if (cmd_valid !== 1'b1 || cmd !== 3'h0)
            $display("FAIL bp_emit: got valid=%b cmd=%h expected valid=1 cmd=0", cmd_valid, cmd);
        else pass_cnt++;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        hold_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
            if (cmd_valid !== 1'b1 || in_ready !== 1'b0) hold_bad = 1'b1;
        end
        total_cnt++; if (hold_bad !== 1'b0) $display("FAIL bp_hold: got %b expected 0", hold_bad); else pass_cnt++;
        out_ready = 1'b1;
        idle_cycle();
        total_cnt++; if (cmd_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", cmd_valid, in_ready);
        else pass_cnt++;
        idle_cycle();
        in_valid = 1'b0;
        send_byte(8'h04);
        send_byte(8'hA1);
        total_cnt++; if (cmd_valid !== 1'b1 || cmd !== 3'h4 || err_count !== 4'd3)
            $display("FAIL bp_next_frame: got valid=%b cmd=%h count=%0d expected 1/4/3", cmd_valid, cmd, err_count);
        else pass_cnt++;
        idle_cycle();
        $display("txn back pressure frame cmd=%h", cmd);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            send_byte(8'hA5);
            send_byte(8'h07);
            idle_cycle();
            if (i == 4) begin
                total_cnt++; if (err_count !== 4'd8) $display("FAIL sat_mid: got %0d expected 8", err_count); else pass_cnt++;
            end
        end
        total_cnt++; if (err_count !== 4'd15 || err_code !== 2'd1)
            $display("FAIL sat_final: got count=%0d code=%0d expected 15/1", err_count, err_code);
        else pass_cnt++;
        total_cnt++; if (cmd !== 3'h4) $display("FAIL sat_cmd: got %h expected 4", cmd); else pass_cnt++;
        $display("txn saturation err_count=%0d", err_count);
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hA5);
        send_byte(8'h03);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (cmd !== 3'h0 || cmd_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rstmid_out: got cmd=%h valid=%b ready=%b expected 0/0/1", cmd, cmd_valid, in_ready);
        else pass_cnt++;
        total_cnt++; if (err_count !== 4'd0 || err_code !== 2'd0 || err_pulse !== 1'b0)
            $display("FAIL rstmid_err: got count=%0d code=%0d pulse=%b expected 0/0/0", err_count, err_code, err_pulse);
        else pass_cnt++;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_byte(8'hA6);
        total_cnt++; if (cmd_valid !== 1'b0) $display("FAIL rstmid_no_emit: got %b expected 0", cmd_valid); else pass_cnt++;
        send_byte(8'h00);
        total_cnt++; if (err_pulse !== 1'b0 || err_code !== 2'd0)
            $display("FAIL rstmid_no_err: got pulse=%b code=%0d expected 0/0", err_pulse, err_code);
        else pass_cnt++;
        $display("txn reset mid-frame done");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic_frame();
        test_bad_opcode();
        test_bad_checksum();
        test_timeout();
        test_back_pressure();
        test_saturation();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Guards against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
